// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel gradient stage: derived widths
// and the magnitude saturation helper.
package sobel_pkg;

    // Container width for the saturation helper; covers WIDTH_P up to 27.
    localparam int SAT_W = 32;

    // Signed gradient width: 4*max pixel fits with sign in WIDTH_P+3 bits.
    function automatic int grad_w(input int w);
        return w + 3;
    endfunction

    // Unsigned magnitude width for |Gx|+|Gy|.
    function automatic int mag_w(input int w);
        return w + 4;
    endfunction

    // Clamp a magnitude to the largest w-bit value.
    function automatic logic [SAT_W-1:0] saturate(
        input logic [SAT_W-1:0] mag,
        input int               w
    );
        logic [SAT_W-1:0] lim;
        lim = (SAT_W'(1) << w) - SAT_W'(1);
        return (mag > lim) ? lim : mag;
    endfunction

endpackage

// File: rtl/sobel_if.sv
// Column-in / gradient-out stream bundle for sobel_kernel.
// slave: kernel side; master: upstream feeder + downstream sink side.
interface sobel_if #(
    parameter int WIDTH_P = 8
);
    logic               valid_i;
    logic               ready_o;
    logic [WIDTH_P-1:0] row0_i;
    logic [WIDTH_P-1:0] row1_i;
    logic [WIDTH_P-1:0] row2_i;
    logic               valid_o;
    logic               ready_i;
    logic [WIDTH_P-1:0] data_o;
    logic               last_o;

    modport slave (
        input  valid_i, row0_i, row1_i, row2_i, ready_i,
        output ready_o, valid_o, data_o, last_o
    );

    modport master (
        output valid_i, row0_i, row1_i, row2_i, ready_i,
        input  ready_o, valid_o, data_o, last_o
    );
endinterface

// File: rtl/sobel_window3x3.sv
// 3x3 column shift window with raster col/row tracking and
// window-valid / frame-last generation (pipeline stage S0).
// Ports: clk_i, rst_i (sync, active-high), en_i (pipeline advance),
//   acc_i (column accepted), row0_i..row2_i (incoming column),
//   win_o[row][col] (col 2 newest), valid_o / last_o (S0 qualifiers).
module sobel_window3x3
    import sobel_pkg::*;
#(
    parameter int WIDTH_P = 8,
    parameter int IMG_W_P = 640,
    parameter int IMG_H_P = 480
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               acc_i,
    input  logic [WIDTH_P-1:0] row0_i,
    input  logic [WIDTH_P-1:0] row1_i,
    input  logic [WIDTH_P-1:0] row2_i,
    output logic [WIDTH_P-1:0] win_o [3][3],
    output logic               valid_o,
    output logic               last_o
);

    localparam int CW = $clog2(IMG_W_P);
    localparam int RW = $clog2(IMG_H_P);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_end;
    logic          row_end;
    logic          interior;

    assign col_end  = (col == CW'(IMG_W_P - 1));
    assign row_end  = (row == RW'(IMG_H_P - 1));
    // Columns left over from the previous row are masked by col < 2.
    assign interior = (col >= CW'(2)) && (row >= RW'(2));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col     <= '0;
            row     <= '0;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_o[r][c] <= '0;
                end
            end
        end else begin
            // Bubbles advance with the pipe, so valid drops on idle beats.
            if (en_i) begin
                valid_o <= acc_i && interior;
                last_o  <= acc_i && col_end && row_end;
            end
            if (acc_i) begin
                for (int r = 0; r < 3; r++) begin
                    win_o[r][0] <= win_o[r][1];
                    win_o[r][1] <= win_o[r][2];
                end
                win_o[0][2] <= row0_i;
                win_o[1][2] <= row1_i;
                win_o[2][2] <= row2_i;
                if (col_end) begin
                    col <= '0;
                    row <= row_end ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sobel_kernel.sv
// Streaming 3x3 Sobel stage: window (S0), signed Gx/Gy (S1),
// saturated |Gx|+|Gy| (S2). Latency 3, one global advance enable.
// Ports: clk_i, rst_i (sync, active-high), bus (sobel_if.slave:
//   valid_i/ready_o/row0_i..row2_i in, valid_o/ready_i/data_o/last_o out).
module sobel_kernel
    import sobel_pkg::*;
#(
    parameter int WIDTH_P = 8,
    parameter int IMG_W_P = 640,
    parameter int IMG_H_P = 480
) (
    input  logic    clk_i,
    input  logic    rst_i,
    sobel_if.slave  bus
);

    localparam int GW = grad_w(WIDTH_P);
    localparam int MW = mag_w(WIDTH_P);

    logic               en;
    logic               acc;
    logic [WIDTH_P-1:0] win [3][3];
    logic               s0_valid;
    logic               s0_last;

    logic signed [GW-1:0] px [3][3];
    logic signed [GW-1:0] gx_n;
    logic signed [GW-1:0] gy_n;

    logic signed [GW-1:0] gx;
    logic signed [GW-1:0] gy;
    logic                 s1_valid;
    logic                 s1_last;

    logic [GW-1:0]        absx;
    logic [GW-1:0]        absy;
    logic [MW-1:0]        mag;
    logic [SAT_W-1:0]     sat_w;
    logic [SAT_W-WIDTH_P-1:0] sat_unused;
    logic [WIDTH_P-1:0]   win_unused;

    logic               valid_q;
    logic               last_q;
    logic [WIDTH_P-1:0] data_q;

    // Every stage, bubbles included, moves only when the output slot frees.
    assign en  = ~valid_q | bus.ready_i;
    assign acc = bus.valid_i & en;

    assign bus.ready_o = en;
    assign bus.valid_o = valid_q;
    assign bus.last_o  = last_q;
    assign bus.data_o  = data_q;

    sobel_window3x3 #(
        .WIDTH_P (WIDTH_P),
        .IMG_W_P (IMG_W_P),
        .IMG_H_P (IMG_H_P)
    ) u_win (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (en),
        .acc_i   (acc),
        .row0_i  (bus.row0_i),
        .row1_i  (bus.row1_i),
        .row2_i  (bus.row2_i),
        .win_o   (win),
        .valid_o (s0_valid),
        .last_o  (s0_last)
    );

    // The centre tap carries no weight in either Sobel kernel.
    assign win_unused = win[1][1];

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                px[r][c] = $signed({{(GW-WIDTH_P){1'b0}}, win[r][c]});
            end
        end
        gx_n = (px[0][2] + (px[1][2] <<< 1) + px[2][2])
             - (px[0][0] + (px[1][0] <<< 1) + px[2][0]);
        gy_n = (px[2][0] + (px[2][1] <<< 1) + px[2][2])
             - (px[0][0] + (px[0][1] <<< 1) + px[0][2]);
    end

    always_comb begin
        absx  = gx[GW-1] ? GW'(-gx) : GW'(gx);
        absy  = gy[GW-1] ? GW'(-gy) : GW'(gy);
        mag   = {1'b0, absx} + {1'b0, absy};
        sat_w = saturate({{(SAT_W-MW){1'b0}}, mag}, WIDTH_P);
    end

    assign sat_unused = sat_w[SAT_W-1:WIDTH_P];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gx       <= '0;
            gy       <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= '0;
        end else if (en) begin
            gx       <= gx_n;
            gy       <= gy_n;
            s1_valid <= s0_valid;
            s1_last  <= s0_last;
            valid_q  <= s1_valid;
            last_q   <= s1_last;
            data_q   <= sat_w[WIDTH_P-1:0];
        end
    end

endmodule

// File: tb/tb_sobel_kernel.sv
// Directed bench for sobel_kernel on a 5x4 frame, 8-bit pixels.
// Expected outputs are hand-derived per scenario.
module tb_sobel_kernel;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    sobel_if #(.WIDTH_P(8)) bus ();

    sobel_kernel #(
        .WIDTH_P (8),
        .IMG_W_P (5),
        .IMG_H_P (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cc22     = 0;

    logic [7:0] q_data [$];
    logic       q_last [$];
    int         q_cyc  [$];

    always @(posedge clk) cyc <= cyc + 1;

    // A transfer happens at the next posedge when valid_o & ready_i here.
    always @(negedge clk) begin
        if (!rst_i && bus.valid_o && bus.ready_i) begin
            q_data.push_back(bus.data_o);
            q_last.push_back(bus.last_o);
            q_cyc.push_back(cyc);
        end
    end

    // kind 0: flat 100, 1: vertical edge at col 2, 2: ramp 10*row
    function automatic logic [7:0] pix(input int kind, input int c, input int r);
        case (kind)
            0:       return 8'd100;
            1:       return (c < 2) ? 8'd0 : 8'd255;
            default: return (r < 0) ? 8'd0 : 8'(10 * r);
        endcase
    endfunction

    task automatic clear_q();
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, output int acc_cyc);
        int   n;
        logic acc;
        n       = 0;
        acc     = 1'b0;
        acc_cyc = -1;
        bus.valid_i = 1'b1;
        bus.row0_i  = a;
        bus.row1_i  = b;
        bus.row2_i  = c;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc     = bus.ready_o;
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: ready_o=%0b required 1", bus.ready_o);
        end
        bus.valid_i = 1'b0;
    endtask

    task automatic send_frame(input int kind, input bit gap);
        int a;
        @(posedge clk);
        #1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) begin
                send(pix(kind, c, r - 2), pix(kind, c, r - 1),
                     pix(kind, c, r), a);
                if (r == 2 && c == 2) cc22 = a;
                if (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic wait_outs(input int n);
        int t;
        t = 0;
        while (q_data.size() < n && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %0b required 0", bus.valid_o);
        end
        checks++;
        if (bus.data_o !== 8'd0) begin
            failures++;
            $display("FAIL reset_data: got %0d required 0", bus.data_o);
        end
        checks++;
        if (bus.last_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_last: got %0b required 0", bus.last_o);
        end
        checks++;
        if (bus.ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %0b required 1", bus.ready_o);
        end
    endtask

    task automatic test_flat();
        clear_q();
        send_frame(0, 1'b0);
        wait_outs(6);
        checks++;
        if (q_data.size() != 6) begin
            failures++;
            $display("FAIL flat_count: got %0d required 6", q_data.size());
        end
        for (int i = 0; i < q_data.size(); i++) begin
            checks++;
            if (q_data[i] !== 8'd0 || q_last[i] !== (i == 5)) begin
                failures++;
                $display("FAIL flat_out[%0d]: got data=%0d last=%0b required data=0 last=%0b",
                         i, q_data[i], q_last[i], (i == 5));
            end
        end
        checks++;
        if (q_cyc.size() == 0 || q_cyc[0] - cc22 != 3) begin
            failures++;
            $display("FAIL flat_latency: got %0d required 3",
                     (q_cyc.size() == 0) ? -1 : q_cyc[0] - cc22);
        end
    endtask

    task automatic test_edge();
        logic [7:0] e [6];
        e = '{8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0};
        clear_q();
        send_frame(1, 1'b0);
        wait_outs(6);
        checks++;
        if (q_data.size() != 6) begin
            failures++;
            $display("FAIL edge_count: got %0d required 6", q_data.size());
        end
        for (int i = 0; i < q_data.size() && i < 6; i++) begin
            checks++;
            if (q_data[i] !== e[i] || q_last[i] !== (i == 5)) begin
                failures++;
                $display("FAIL edge_out[%0d]: got data=%0d last=%0b required data=%0d last=%0b",
                         i, q_data[i], q_last[i], e[i], (i == 5));
            end
        end
    endtask

    task automatic test_ramp();
        clear_q();
        send_frame(2, 1'b0);
        wait_outs(6);
        checks++;
        if (q_data.size() != 6) begin
            failures++;
            $display("FAIL ramp_count: got %0d required 6", q_data.size());
        end
        for (int i = 0; i < q_data.size(); i++) begin
            checks++;
            if (q_data[i] !== 8'd80 || q_last[i] !== (i == 5)) begin
                failures++;
                $display("FAIL ramp_out[%0d]: got data=%0d last=%0b required data=80 last=%0b",
                         i, q_data[i], q_last[i], (i == 5));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] e [6];
        logic [7:0] hd;
        logic       hl;
        int         t;
        e = '{8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0};
        clear_q();
        fork
            send_frame(1, 1'b0);
            begin
                t = 0;
                do begin
                    @(posedge clk);
                    #1;
                    t++;
                end while (!bus.valid_o && t < 300);
                checks++;
                if (!bus.valid_o) begin
                    failures++;
                    $display("FAIL bp_wait_valid: got %0b required 1", bus.valid_o);
                end else begin
                    bus.ready_i = 1'b0;
                    hd = bus.data_o;
                    hl = bus.last_o;
                    repeat (5) begin
                        @(negedge clk);
                        checks++;
                        if (bus.ready_o !== 1'b0 || bus.valid_o !== 1'b1 ||
                            bus.data_o !== hd || bus.last_o !== hl) begin
                            failures++;
                            $display("FAIL bp_hold: got rdy=%0b vld=%0b data=%0d last=%0b required rdy=0 vld=1 data=%0d last=%0b",
                                     bus.ready_o, bus.valid_o, bus.data_o,
                                     bus.last_o, hd, hl);
                        end
                    end
                    @(posedge clk);
                    #1;
                    bus.ready_i = 1'b1;
                end
            end
        join
        wait_outs(6);
        checks++;
        if (q_data.size() != 6) begin
            failures++;
            $display("FAIL bp_count: got %0d required 6", q_data.size());
        end
        for (int i = 0; i < q_data.size() && i < 6; i++) begin
            checks++;
            if (q_data[i] !== e[i] || q_last[i] !== (i == 5)) begin
                failures++;
                $display("FAIL bp_out[%0d]: got data=%0d last=%0b required data=%0d last=%0b",
                         i, q_data[i], q_last[i], e[i], (i == 5));
            end
        end
    endtask

    task automatic test_toggle();
        clear_q();
        send_frame(0, 1'b1);
        wait_outs(6);
        checks++;
        if (q_data.size() != 6) begin
            failures++;
            $display("FAIL toggle_count: got %0d required 6", q_data.size());
        end
        for (int i = 0; i < q_data.size(); i++) begin
            checks++;
            if (q_data[i] !== 8'd0 || q_last[i] !== (i == 5)) begin
                failures++;
                $display("FAIL toggle_out[%0d]: got data=%0d last=%0b required data=0 last=%0b",
                         i, q_data[i], q_last[i], (i == 5));
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] e [6];
        int         a;
        e = '{8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            send(pix(1, i % 5, i / 5 - 2), pix(1, i % 5, i / 5 - 1),
                 pix(1, i % 5, i / 5), a);
        end
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
            failures++;
            $display("FAIL midrst_state: got vld=%0b rdy=%0b required vld=0 rdy=1",
                     bus.valid_o, bus.ready_o);
        end
        clear_q();
        send_frame(1, 1'b0);
        wait_outs(6);
        checks++;
        if (q_data.size() != 6) begin
            failures++;
            $display("FAIL midrst_count: got %0d required 6", q_data.size());
        end
        for (int i = 0; i < q_data.size() && i < 6; i++) begin
            checks++;
            if (q_data[i] !== e[i] || q_last[i] !== (i == 5)) begin
                failures++;
                $display("FAIL midrst_out[%0d]: got data=%0d last=%0b required data=%0d last=%0b",
                         i, q_data[i], q_last[i], e[i], (i == 5));
            end
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        bus.valid_i = 1'b0;
        bus.row0_i  = '0;
        bus.row1_i  = '0;
        bus.row2_i  = '0;
        bus.ready_i = 1'b1;
        test_reset();
        test_flat();
        test_edge();
        test_ramp();
        test_backpressure();
        test_toggle();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
